// File: rtl/comp_seq_ctrl_pkg.sv
// comp_pkg: shared types and constants for the sequential slice comparator.
//   state_e      - controller FSM states (idle, run, done)
//   slice_res_e  - encoded result of one 2-bit slice comparison
//   SLICE_W      - width of the shared slice comparator
//   slice_encode - maps the one-hot eq/gt/lt outputs onto slice_res_e
package comp_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // SliceErr is never produced by a healthy comparator; it exists so the
  // encoding is total and a broken one-hot vector is not mistaken for a result.
  typedef enum logic [1:0] {
    SliceEq  = 2'b00,
    SliceGt  = 2'b01,
    SliceLt  = 2'b10,
    SliceErr = 2'b11
  } slice_res_e;

  function automatic slice_res_e slice_encode(input logic eq, input logic gt, input logic lt);
    slice_res_e res;
    unique case ({eq, gt, lt})
      3'b100:  res = SliceEq;
      3'b010:  res = SliceGt;
      3'b001:  res = SliceLt;
      default: res = SliceErr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/comp_seq_ctrl_if.sv
// comp_seq_ctrl_if: producer/consumer handshake bundle for comp_seq_ctrl.
//   in_valid/in_ready  - operand handshake (a, b sampled on acceptance)
//   out_valid/out_ready - result handshake (aeb, agb, alb one-hot while valid)
// Modports:
//   slave  - the comparator side
//   master - the producer/consumer side (testbench or surrounding logic)
interface comp_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             aeb;
  logic             agb;
  logic             alb;

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output aeb,
    output agb,
    output alb
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  aeb,
    input  agb,
    input  alb
  );

endinterface

// File: rtl/comp_seq_ctrl_slice2.sv
// comp_slice2: combinational 2-bit magnitude comparator.
//   a, b       - 2-bit unsigned slices
//   eq, gt, lt - one-hot comparison result (a==b, a>b, a<b)
module comp_slice2
  import comp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule

// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: compares two WIDTH-bit operands one 2-bit slice per cycle,
// MSB slice first, stopping at the first unequal slice.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - comp_seq_ctrl_if.slave: in_valid/in_ready/a/b operand handshake,
//           out_valid/out_ready/aeb/agb/alb result handshake
// Parameters:
//   WIDTH - operand width, even and >= 2 (NSLICE = WIDTH/2 slices)
// Build option:
//   COMP_SEQ_SIGNED_CMP_EN - when defined, operands are two's complement; the
//   sign bit is inverted in the MSB slice only (offset-binary mapping).
module comp_seq_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  comp_seq_ctrl_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NSLICE - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               out_valid_q;
  logic               aeb_q;
  logic               agb_q;
  logic               alb_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic               slice_eq;
  logic               slice_gt;
  logic               slice_lt;
  slice_res_e         slice_res;

  // Select the current slice with constant part-selects to keep the mux explicit.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < int'(NSLICE); i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_q[i*SLICE_W +: SLICE_W];
        slice_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
`ifdef COMP_SEQ_SIGNED_CMP_EN
    // Flipping the sign bit turns two's complement ordering into unsigned ordering.
    if (idx_q == IDX_MAX) begin
      slice_a[SLICE_W-1] = ~slice_a[SLICE_W-1];
      slice_b[SLICE_W-1] = ~slice_b[SLICE_W-1];
    end
`endif
  end

  comp_slice2 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .eq (slice_eq),
    .gt (slice_gt),
    .lt (slice_lt)
  );

  assign slice_res = slice_encode(slice_eq, slice_gt, slice_lt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      aeb_q       <= 1'b0;
      agb_q       <= 1'b0;
      alb_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            idx_q   <= IDX_MAX;
            state_q <= StRun;
          end
        end

        StRun: begin
          unique case (slice_res)
            SliceGt: begin
              agb_q       <= 1'b1;
              alb_q       <= 1'b0;
              aeb_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
            SliceLt: begin
              agb_q       <= 1'b0;
              alb_q       <= 1'b1;
              aeb_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
            SliceEq: begin
              if (idx_q == '0) begin
                aeb_q       <= 1'b1;
                agb_q       <= 1'b0;
                alb_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end else begin
                idx_q <= idx_q - 1'b1;
              end
            end
            default: begin
              // Comparator produced a non one-hot result; abandon the operation.
              state_q <= StIdle;
            end
          endcase
        end

        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            aeb_q       <= 1'b0;
            agb_q       <= 1'b0;
            alb_q       <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          aeb_q       <= 1'b0;
          agb_q       <= 1'b0;
          alb_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.aeb       = aeb_q;
  assign bus.agb       = agb_q;
  assign bus.alb       = alb_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed testbench for comp_seq_ctrl at WIDTH=8.
module tb_comp_seq_ctrl;

`ifdef COMP_SEQ_SIGNED_CMP_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  comp_seq_ctrl_if #(.WIDTH(8)) bus ();

  comp_seq_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one pair once in_ready is seen, then counts edges after the
  // accepting edge until out_valid (bounded). scramble rewrites a/b every cycle.
  task automatic run_pair(input logic [7:0] ta, input logic [7:0] tb_v, input bit scramble,
                          output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    bus.a        = ta;
    bus.b        = tb_v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (scramble) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 10000",
               {bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: got %b want 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_equal();
    int lat;
    bus.out_ready = 1'b1;
    run_pair(8'hA5, 8'hA5, 1'b0, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL equal_latency: got %0d want 4", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL equal_flags: got %b want 1100",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL equal_back_idle: got %b want 10000",
               {bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
  endtask

  task automatic test_early_exit();
    int lat;
    logic [3:0] want;
    want = SIGNED_EN ? 4'b1001 : 4'b1010;  // -64 < 64 signed, 192 > 64 unsigned
    run_pair(8'hC0, 8'h40, 1'b0, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL early_latency: got %0d want 1", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== want) begin
      tests_failed++;
      $display("FAIL early_flags: got %b want %b",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb}, want);
    end
  endtask

  task automatic test_lsb_decision();
    int lat;
    run_pair(8'h12, 8'h13, 1'b0, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL lsb_lt_latency: got %0d want 4", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL lsb_lt_flags: got %b want 1001",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
    run_pair(8'h13, 8'h12, 1'b0, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL lsb_gt_latency: got %0d want 4", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL lsb_gt_flags: got %b want 1010",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_pair(8'h01, 8'h01, 1'b0, lat);  // leaves DONE -> IDLE with out_ready=1
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    // 0x30 vs 0x20: slice 3 equal, slice 2 is 3 vs 2 -> greater after 2 edges.
    run_pair(8'h30, 8'h20, 1'b0, lat);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL bp_latency: got %0d want 2", lat);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        bus.a        = 8'h55;
        bus.b        = 8'h55;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      tests_run++;
      if ({bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 5'b01010) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got %b want 01010", i,
                 {bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb});
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL bp_release: got %b want 10000",
               {bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_pulse_ignored: got %b want 10", {bus.in_ready, bus.out_valid});
    end
    run_pair(8'h01, 8'h02, 1'b0, lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL bp_second_latency: got %0d want 4", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL bp_second_flags: got %b want 1001",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
  endtask

  task automatic test_isolation();
    int lat;
    run_pair(8'h5A, 8'h5B, 1'b1, lat);
    bus.a = 8'h00;
    bus.b = 8'h00;
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL iso_latency: got %0d want 4", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL iso_flags: got %b want 1001",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int n;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    bus.a        = 8'h00;
    bus.b        = 8'h01;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rst_run_%0d: got %b want 00", i, {bus.in_ready, bus.out_valid});
      end
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL rst_mid_assert: got %b want 10000",
               {bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 5'b10000) begin
        tests_failed++;
        $display("FAIL rst_mid_hold_%0d: got %b want 10000", i,
                 {bus.in_ready, bus.out_valid, bus.aeb, bus.agb, bus.alb});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_mid_no_result: got %b want 10", {bus.in_ready, bus.out_valid});
    end
    // 0x20 vs 0x0A: slice 3 equal, slice 2 is 2 vs 0 -> greater after 2 edges.
    run_pair(8'h20, 8'h0A, 1'b0, lat);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL rst_resume_latency: got %0d want 2", lat);
    end
    tests_run++;
    if ({bus.out_valid, bus.aeb, bus.agb, bus.alb} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL rst_resume_flags: got %b want 1010",
               {bus.out_valid, bus.aeb, bus.agb, bus.alb});
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    test_reset();
    test_equal();
    test_early_exit();
    test_lsb_decision();
    test_backpressure();
    test_isolation();
    test_reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/comp_seq_ctrl.md
Name: comp_seq_ctrl

Overview:
- Sequencer that compares two WIDTH-bit operands by stepping a single shared 2-bit slice comparator from the MSB slice down to the LSB slice.
- Stops at the first unequal slice.
- Sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides.
- Used where a full-width comparator costs too much area and multi-cycle latency is acceptable.

Parameters:
- WIDTH, default 8: operand width in bits. Must be even and at least 2. NSLICE = WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, sampled at the input handshake.
- b  input  WIDTH  operand B, sampled at the input handshake.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- aeb  output  1  A equals B.
- agb  output  1  A greater than B.
- alb  output  1  A less than B.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, out_valid 0, aeb/agb/alb 0, slice index 0, operand registers 0.
- in_ready is combinational: in_ready = (state == IDLE). It is 1 during and immediately after reset.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready at edge E0: capture a and b into registers, set idx = NSLICE-1, go to RUN.
- RUN, one slice per cycle. The slice comparator evaluates a_r[2*idx+1:2*idx] against b_r[2*idx+1:2*idx]:
  - Slice unequal: at this edge, load agb/alb from the slice result, aeb=0, out_valid=1, go to DONE.
  - Slice equal and idx==0: load aeb=1, agb=0, alb=0, out_valid=1, go to DONE.
  - Slice equal and idx>0: idx decrements, stay in RUN.
- Latency: k rising edges after E0, where k is the number of slices examined (1..NSLICE). Fully equal operands take NSLICE edges.
- DONE:
  - out_valid=1. aeb/agb/alb are held stable and exactly one of them is 1.
  - On out_ready at an edge: out_valid=0, aeb/agb/alb cleared to 0, go to IDLE.
  - No new operand is accepted in the same cycle; in_ready rises the cycle after.
- Result flags are 0 whenever out_valid is 0.
- Upstream changes to a/b after E0 have no effect. Only the registered copies are used.
- in_valid asserted while busy is ignored. The producer must hold in_valid until in_ready.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to IDLE with out_valid=0.
  - The pending result is discarded and never presented.
- WIDTH=2: RUN always lasts exactly 1 cycle.

Optional Feature:
- Macro: COMP_SEQ_SIGNED_CMP_EN.
- Defined:
  - Operands are two's complement.
  - During the MSB slice only, bit WIDTH-1 of both a_r and b_r is inverted before reaching the slice comparator (offset-binary mapping).
  - All other slices are unchanged.
  - Equality result and latency are unaffected.
- Undefined: operands are unsigned, with no inversion.

Decomposition:
- Package comp_pkg:
  - State enum (IDLE, RUN, DONE).
  - Constant SLICE_W=2.
  - Slice result encoding: EQ, GT, LT.
- Sub-module comp_slice2:
  - Combinational 2-bit comparator.
  - Inputs: two 2-bit values. Outputs: eq, gt, lt, one-hot.
  - Instantiated once inside comp_seq_ctrl.
- comp_seq_ctrl holds the FSM, slice index counter, operand registers and result registers.

Test Plan (WIDTH=8):
- Equal operands: a=8'hA5, b=8'hA5, out_ready=1 -> out_valid rises 4 edges after E0 with aeb=1, agb=0, alb=0; back in IDLE 1 edge later.
- Early exit: a=8'hC0, b=8'h40, unsigned -> MSB slice 3 vs 1, agb=1, out_valid after 1 edge. Same pair with COMP_SEQ_SIGNED_CMP_EN -> alb=1 (-64 < 64), still 1 edge.
- LSB decision: a=8'h12, b=8'h13 -> alb=1 after 4 edges. Operands swapped -> agb=1 after 4 edges.
- Backpressure: out_ready held 0 for 3 cycles after out_valid -> flags and out_valid stay constant, in_ready stays 0; a second in_valid pulse is not accepted. Raise out_ready -> IDLE, then the second pair is accepted.
- Operand isolation: change a/b every cycle after E0 -> result matches the values sampled at E0.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles of a=8'h00, b=8'h01 -> out_valid never pulses, flags 0, in_ready=1 while in reset. Resume with a fresh pair -> correct result.
